// File: rtl/stn_selftrig_core.sv
// stn_selftrig_core: N-channel self-trigger core.
// Each channel optionally inverts its sample, detects a rising threshold
// crossing, applies a shared holdoff, and parks the crossing timestamp in a
// one-deep pending slot. A round-robin arbiter drains the pending slots into
// a valid/ready record stream. Per-channel saturating trigger/drop counters
// are readable through a registered address port.
module stn_selftrig_core #(
    parameter int NCH = 40,
    parameter int DW  = 14,
    parameter int TSW = 64,
    parameter int HOW = 16,
    parameter int CW  = 32
) (
    input  logic                     aclk,
    input  logic                     reset_aclk,
    input  logic [NCH*DW-1:0]        afe_dat,
    input  logic [TSW-1:0]           timestamp,
    input  logic [NCH-1:0]           enable,
    input  logic [NCH-1:0]           invert_enable,
    input  logic [NCH*DW-1:0]        threshold,
    input  logic [HOW-1:0]           holdoff,
    input  logic                     reset_st_counters,
    output logic                     trig_valid,
    input  logic                     trig_ready,
    output logic [$clog2(NCH)-1:0]   trig_channel,
    output logic [TSW-1:0]           trig_timestamp,
    input  logic [$clog2(NCH)-1:0]   cnt_addr,
    input  logic                     cnt_sel,
    output logic [CW-1:0]            cnt_data
);

    localparam int CHW = $clog2(NCH);

    // Shared stage-1 timestamp, aligned with every channel's d1 sample
    logic [TSW-1:0] ts1_reg;

    // Per-channel state gathered for the arbiter and readback mux
    logic [NCH-1:0] pend_vec;
    logic [NCH-1:0] grant_vec;
    logic [TSW-1:0] pts_arr      [NCH];
    logic [CW-1:0]  trig_cnt_arr [NCH];
    logic [CW-1:0]  drop_cnt_arr [NCH];

    // Arbiter signals
    logic [CHW-1:0] ptr_reg;
    logic [CHW-1:0] ptr_next;
    logic [CHW-1:0] grant_idx;
    logic [CHW:0]   cand;
    logic           grant_found;
    logic           out_free;
    logic           grant_en;

    // Register the timestamp alongside the stage-1 samples
    always_ff @(posedge aclk or posedge reset_aclk) begin
        if (reset_aclk) begin
            ts1_reg <= '0;
        end else begin
            ts1_reg <= timestamp;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NCH; gi++) begin : g_ch
            logic [DW-1:0]  x_in;
            logic [DW-1:0]  thr;
            logic [DW-1:0]  d1_reg;
            logic [DW-1:0]  d1p_reg;
            logic [HOW-1:0] ho_cnt_reg;
            logic           pend_reg;
            logic [TSW-1:0] pts_reg;
            logic [CW-1:0]  trig_cnt_reg;
            logic [CW-1:0]  drop_cnt_reg;
            logic           xing;
            logic           acc;
            logic           take;

            assign x_in = afe_dat[gi*DW +: DW];
            assign thr  = threshold[gi*DW +: DW];

            // Rising crossing: current sample at/above threshold, previous below
            assign xing = enable[gi] & (d1_reg >= thr) & (d1p_reg < thr);
            assign acc  = xing & (ho_cnt_reg == '0);
            // The slot can take a new event when empty or being drained this cycle
            assign take = acc & (~pend_reg | grant_vec[gi]);

            // Stage 1: polarity-corrected sample and its predecessor.
            // (2^DW-1) - x is exactly the bitwise complement of x.
            always_ff @(posedge aclk or posedge reset_aclk) begin
                if (reset_aclk) begin
                    d1_reg  <= '0;
                    d1p_reg <= '0;
                end else begin
                    d1_reg  <= invert_enable[gi] ? ~x_in : x_in;
                    d1p_reg <= d1_reg;
                end
            end

            // Holdoff: reload on an accepted crossing, otherwise count down to zero
            always_ff @(posedge aclk or posedge reset_aclk) begin
                if (reset_aclk) begin
                    ho_cnt_reg <= '0;
                end else if (acc) begin
                    ho_cnt_reg <= holdoff;
                end else if (ho_cnt_reg != '0) begin
                    ho_cnt_reg <= ho_cnt_reg - HOW'(1);
                end
            end

            // Pending slot: first event wins; a grant frees the slot
            always_ff @(posedge aclk or posedge reset_aclk) begin
                if (reset_aclk) begin
                    pend_reg <= 1'b0;
                    pts_reg  <= '0;
                end else if (take) begin
                    pend_reg <= 1'b1;
                    pts_reg  <= ts1_reg;
                end else if (grant_vec[gi]) begin
                    pend_reg <= 1'b0;
                end
            end

            // Saturating trigger/drop counters; the clear beats an increment
            always_ff @(posedge aclk or posedge reset_aclk) begin
                if (reset_aclk) begin
                    trig_cnt_reg <= '0;
                    drop_cnt_reg <= '0;
                end else if (reset_st_counters) begin
                    trig_cnt_reg <= '0;
                    drop_cnt_reg <= '0;
                end else begin
                    if (take && (trig_cnt_reg != '1)) begin
                        trig_cnt_reg <= trig_cnt_reg + CW'(1);
                    end
                    if (acc && !take && (drop_cnt_reg != '1)) begin
                        drop_cnt_reg <= drop_cnt_reg + CW'(1);
                    end
                end
            end

            assign pend_vec[gi]     = pend_reg;
            assign pts_arr[gi]      = pts_reg;
            assign trig_cnt_arr[gi] = trig_cnt_reg;
            assign drop_cnt_arr[gi] = drop_cnt_reg;
        end
    endgenerate

    assign out_free = ~trig_valid | trig_ready;
    assign grant_en = out_free & grant_found;
    assign ptr_next = (grant_idx == CHW'(NCH - 1)) ? '0 : grant_idx + CHW'(1);

    // Round-robin search: first pending channel at or after ptr, wrapping
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int off = 0; off < NCH; off++) begin
            cand = {1'b0, ptr_reg} + (CHW+1)'(off);
            if (cand >= (CHW+1)'(NCH)) begin
                cand = cand - (CHW+1)'(NCH);
            end
            if (!grant_found && pend_vec[cand[CHW-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = cand[CHW-1:0];
            end
        end
    end

    // One-hot grant so each channel can see whether its slot is drained
    always_comb begin
        grant_vec = '0;
        if (grant_en) begin
            grant_vec[grant_idx] = 1'b1;
        end
    end

    // Output record register; holds while stalled by trig_ready
    always_ff @(posedge aclk or posedge reset_aclk) begin
        if (reset_aclk) begin
            trig_valid     <= 1'b0;
            trig_channel   <= '0;
            trig_timestamp <= '0;
            ptr_reg        <= '0;
        end else if (out_free) begin
            if (grant_found) begin
                trig_valid     <= 1'b1;
                trig_channel   <= grant_idx;
                trig_timestamp <= pts_arr[grant_idx];
                ptr_reg        <= ptr_next;
            end else begin
                trig_valid <= 1'b0;
            end
        end
    end

    // Registered counter readback; out-of-range addresses read zero
    always_ff @(posedge aclk or posedge reset_aclk) begin
        if (reset_aclk) begin
            cnt_data <= '0;
        end else if (int'(cnt_addr) < NCH) begin
            cnt_data <= cnt_sel ? drop_cnt_arr[cnt_addr] : trig_cnt_arr[cnt_addr];
        end else begin
            cnt_data <= '0;
        end
    end

endmodule

// File: doc/stn_selftrig_core.md
Name: stn_selftrig_core

Overview:
- Parametrised N-channel self-trigger core; next generation of the fixed 40-channel self-trigger top.
- Per channel: optional polarity inversion, rising threshold-crossing detection, programmable holdoff, and a pending-trigger slot that latches the crossing's timestamp.
- A round-robin arbiter serialises pending triggers into a valid/ready record stream for the frame builder.
- Per-channel saturating trigger and drop counters are readable by address.

Parameters:
- NCH, 40, number of AFE channels.
- DW, 14, sample width.
- TSW, 64, timestamp width.
- HOW, 16, holdoff counter width.
- CW, 32, counter width.

Ports:
- aclk  in  1  sample clock, rising edge.
- reset_aclk  in  1  asynchronous, active-high reset.
- afe_dat  in  NCH*DW  flattened samples; channel i at bits [i*DW +: DW].
- timestamp  in  TSW  free-running timestamp, aligned with afe_dat.
- enable  in  NCH  per-channel trigger enable.
- invert_enable  in  NCH  per-channel polarity inversion.
- threshold  in  NCH*DW  per-channel threshold, flattened like afe_dat.
- holdoff  in  HOW  holdoff length in cycles, shared by all channels.
- reset_st_counters  in  1  synchronous clear of all counters.
- trig_valid  out  1  trigger record valid.
- trig_ready  in  1  downstream accepts the record.
- trig_channel  out  $clog2(NCH)  channel of the record.
- trig_timestamp  out  TSW  timestamp of the crossing sample.
- cnt_addr  in  $clog2(NCH)  counter read channel.
- cnt_sel  in  1  0 = trigger count, 1 = drop count.
- cnt_data  out  CW  counter read data.

Behaviour:
- Reset (asynchronous): all of the following go to 0 — pipeline registers, pending flags, holdoff counters, counters, arbiter pointer, trig_valid, trig_channel, trig_timestamp, cnt_data.
- Stage 1 (edge after sample cycle k):
  - d1[i] <= invert_enable[i] ? (2^DW-1 - x) : x.
  - ts1 <= timestamp.
  - d1p[i] <= previous d1[i].
- Crossing (combinational, unsigned compare): xing[i] = enable[i] & (d1[i] >= thr[i]) & (d1p[i] < thr[i]).
- Accepted crossing: acc[i] = xing[i] & (ho_cnt[i] == 0).
- Holdoff counter, per channel:
  - acc[i] loads ho_cnt[i] <= holdoff.
  - Otherwise ho_cnt[i] decrements while nonzero.
  - holdoff = 0 means only edge detection gates re-triggering.
- Pending slot, per channel, on acc[i]:
  - If pend[i] = 0, or pend[i] is being granted this cycle: pend[i] <= 1, pts[i] <= ts1, trig_cnt[i]++.
  - Else: drop_cnt[i]++; pend[i] and pts[i] are kept (first event wins).
- Disabling a channel suppresses new crossings only. An existing pend[i] is still delivered, and ho_cnt[i] keeps running.
- Arbiter:
  - Output register is free when trig_valid = 0 or trig_ready = 1.
  - When free and any pend[i] = 1, grant the first pending channel at or after ptr, wrapping modulo NCH.
  - On grant: trig_valid <= 1, trig_channel <= g, trig_timestamp <= pts[g], pend[g] cleared, ptr <= (g+1) mod NCH.
  - When free with nothing pending: trig_valid <= 0.
  - While trig_valid = 1 and trig_ready = 0, trig_channel and trig_timestamp hold stable.
- Latency: a crossing sample at cycle k gives trig_valid in cycle k+3 if the output is free. Throughput is 1 record per cycle.
- Counters:
  - Saturate at 2^CW-1.
  - reset_st_counters clears all counters and takes priority over a same-cycle increment.
  - Pending flags and holdoff are unaffected by reset_st_counters.
- Readback: cnt_data registered; 1-cycle latency from cnt_addr/cnt_sel. cnt_addr >= NCH returns 0.
- Reset asserted mid-record drops the pending record and any record in flight. No record is emitted after reset deasserts until a new crossing occurs.

Test Plan:
- Single crossing: NCH=4, thr[2]=1000, ch2 samples 900 then 1100 at ts=0x50, holdoff=10 -> one record {ch 2, ts 0x50}, trig_valid 3 cycles after the 1100 sample; trig_cnt[2]=1.
- Inversion: invert_enable[1]=1, thr[1]=15000, raw samples 2000 -> 1000 (inverted 14383 -> 15383) -> one record on ch1; with invert_enable[1]=0 -> no record.
- Holdoff and drop:
  - holdoff=8, ch0 crosses at cycles 0 and 4 -> second crossing ignored, trig_cnt=1, drop_cnt=0.
  - holdoff=0 with trig_ready=0, ch0 crosses 3 times -> 1 record delivered with the first timestamp, trig_cnt=2, drop_cnt=1.
- Round-robin: ch0, ch1, ch3 cross in the same cycle with trig_ready=1 -> records in order 0, 1, 3 on consecutive cycles; a subsequent simultaneous ch0+ch3 crossing with ptr at 0 -> order 0, 3.
- Backpressure: trig_ready=0 for 5 cycles with trig_valid high -> channel and timestamp stable; releasing ready -> next pending record the following cycle.
- Counters and reset:
  - Preload trig_cnt to 2^32-2 (CW=32), two crossings -> reads 0xFFFFFFFF.
  - reset_st_counters coincident with a crossing -> count reads 0.
  - reset_aclk asserted during backpressure -> trig_valid=0 immediately.
